// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : 8N1 UART transmitter with a small valid/ready input FIFO.
//                Bytes are sent LSB first with one start and one stop bit;
//                consecutive queued bytes are sent back to back.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx #(
    parameter int BAUD_DIVISOR = 868,
    parameter int FIFO_AW      = 2
) (
    input  logic               clk100,
    input  logic               rst,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               tx,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int                 DEPTH    = 1 << FIFO_AW;
    localparam logic [9:0]         C_RELOAD = 10'(BAUD_DIVISOR - 1);
    localparam logic [FIFO_AW:0]   C_DEPTH  = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t               state_q;
    logic [9:0]           timer_q;
    logic [2:0]           bitcnt_q;
    logic [7:0]           shift_q;
    logic                 tx_q;

    logic [7:0]           mem_q [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q;
    logic [FIFO_AW-1:0]   rd_ptr_q;
    logic [FIFO_AW:0]     level_q;
    logic [FIFO_AW:0]     level_d;

    logic                 push;
    logic                 pop;
    logic                 bit_end;

    // Ready depends only on the registered level, never on tx_valid.
    assign tx_ready = (level_q != C_DEPTH);
    assign push     = tx_valid && tx_ready;
    assign bit_end  = (timer_q == 10'd0);

    // A new frame is loaded from IDLE, or straight out of STOP so frames abut.
    assign pop = (level_q != '0) &&
                 ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE) || (level_q != '0);
    assign fifo_level = level_q;

    // Occupancy count: simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers are flushed.
    always_ff @(posedge clk100) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    // FIFO pointers and level; reset flushes any queued bytes.
    always_ff @(posedge clk100) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
        end
    end

    // Serialiser FSM: bit timer, bit counter, shift register and line driver.
    always_ff @(posedge clk100) begin
        if (rst) begin
            state_q  <= S_IDLE;
            timer_q  <= 10'd0;
            bitcnt_q <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
        end else begin
            if (!bit_end) begin
                timer_q <= timer_q - 10'd1;
            end
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        tx_q    <= 1'b0;
                        timer_q <= C_RELOAD;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        tx_q     <= shift_q[0];
                        shift_q  <= {1'b0, shift_q[7:1]};
                        bitcnt_q <= 3'd0;
                        timer_q  <= C_RELOAD;
                        state_q  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        timer_q <= C_RELOAD;
                        if (bitcnt_q != 3'd7) begin
                            tx_q     <= shift_q[0];
                            shift_q  <= {1'b0, shift_q[7:1]};
                            bitcnt_q <= bitcnt_q + 3'd1;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shift_q <= mem_q[rd_ptr_q];
                            tx_q    <= 1'b0;
                            timer_q <= C_RELOAD;
                            state_q <= S_START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Scoreboard bench for uart_tx (BAUD_DIVISOR=4, FIFO_AW=2).
//                Accepted bytes are queued as expected frames; a line monitor
//                decodes tx and compares each decoded byte against the queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx;

    localparam int BD = 4;

    logic       clk100   = 1'b0;
    logic       rst      = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_level;

    int         total    = 0;
    int         bad      = 0;
    int         cyc      = 0;
    int         n_frames = 0;
    logic [7:0] exp_q [$];
    int         start_q [$];

    uart_tx #(
        .BAUD_DIVISOR (BD),
        .FIFO_AW      (2)
    ) dut (
        .clk100     (clk100),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk100 = ~clk100;

    always @(posedge clk100) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk100);
        #1;
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        while (busy && n < bound) begin
            step();
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout actual=busy required=idle within %0d cycles", bound);
        end
    endtask

    // Scoreboard producer and line monitor, both sampled on the falling edge.
    initial begin : monitor
        bit         act_f;
        int         cnt;
        logic [7:0] sh;
        logic [7:0] e;
        act_f = 1'b0;
        cnt   = 0;
        sh    = 8'h00;
        forever begin
            @(negedge clk100);
            if (rst) begin
                act_f = 1'b0;
                exp_q.delete();
            end else begin
                if (tx_valid && tx_ready) exp_q.push_back(tx_data);
                if (!act_f) begin
                    if (tx == 1'b0) begin
                        act_f = 1'b1;
                        cnt   = 0;
                        start_q.push_back(cyc);
                    end
                end else begin
                    cnt++;
                    if (cnt == 1) begin
                        chk("start_bit", int'(tx), 0);
                    end else if (cnt >= 5 && cnt <= 33 && (cnt % 4) == 1) begin
                        sh[(cnt - 5) / 4] = tx;
                    end else if (cnt == 37) begin
                        chk("stop_bit", int'(tx), 1);
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_frame actual=%02h required=none", sh);
                        end else begin
                            e = exp_q.pop_front();
                            chk("frame_byte", int'(sh), int'(e));
                        end
                        n_frames++;
                    end else if (cnt == 39) begin
                        act_f = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [9:0] fr;
        int         n;
        int         n0;
        int         rise_i;
        bit         acc;

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        chk("rst_tx", int'(tx), 1);
        chk("rst_ready", int'(tx_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_level", int'(fifo_level), 0);
        rst = 1'b0;
        repeat (2) step();

        // Single byte 0xA5: start, 1,0,1,0,0,1,0,1, stop
        fr = 10'b1_10100101_0;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        step();
        tx_valid = 1'b0;
        chk("a5_level", int'(fifo_level), 1);
        chk("a5_busy", int'(busy), 1);
        chk("a5_tx_at_push", int'(tx), 1);
        for (int k = 1; k <= 40; k++) begin
            step();
            chk("a5_line", int'(tx), int'(fr[(k - 1) / 4]));
        end
        chk("a5_busy_n40", int'(busy), 1);
        step();
        chk("a5_busy_n41", int'(busy), 0);
        chk("a5_tx_idle", int'(tx), 1);
        repeat (3) step();

        // Three consecutive pushes: contiguous frames, level peaks at 2
        start_q.delete();
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        step();
        tx_data  = 8'hFF;
        step();
        tx_data  = 8'h55;
        step();
        tx_valid = 1'b0;
        chk("b2b_level_peak", int'(fifo_level), 2);
        wait_idle(400, n);
        chk("b2b_busy_fall", n, 119);
        chk("b2b_frames", start_q.size(), 3);
        if (start_q.size() == 3) begin
            chk("b2b_gap01", start_q[1] - start_q[0], 40);
            chk("b2b_gap12", start_q[2] - start_q[1], 40);
        end
        repeat (3) step();

        // Fill the FIFO with tx_valid held; bytes 0x10..0x18 must all go out
        n0       = n_frames;
        rise_i   = -1;
        tx_data  = 8'h10;
        tx_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            acc = tx_ready;
            step();
            if (acc) tx_data = tx_data + 8'd1;
            if (i == 4) begin
                chk("full_level", int'(fifo_level), 4);
                chk("full_ready", int'(tx_ready), 0);
            end
            if (i > 4 && rise_i < 0 && tx_ready) rise_i = i;
            if (tx_data == 8'h19) break;
        end
        tx_valid = 1'b0;
        chk("ready_rise", rise_i, 41);
        wait_idle(1000, n);
        repeat (2) step();
        chk("fill_frames", n_frames - n0, 9);
        chk("fill_queue_empty", exp_q.size(), 0);
        repeat (3) step();

        // Reset during data bit 3 with two bytes queued
        tx_valid = 1'b1;
        tx_data  = 8'h81;
        step();
        tx_data  = 8'h42;
        step();
        tx_data  = 8'h99;
        step();
        tx_valid = 1'b0;
        chk("mid_level", int'(fifo_level), 2);
        repeat (16) step();
        chk("mid_bit3", int'(tx), 0);
        rst = 1'b1;
        step();
        chk("mid_rst_tx", int'(tx), 1);
        chk("mid_rst_level", int'(fifo_level), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(tx_ready), 1);
        rst = 1'b0;
        repeat (2) step();
        n0       = n_frames;
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        step();
        tx_valid = 1'b0;
        wait_idle(200, n);
        repeat (2) step();
        chk("post_rst_frames", n_frames - n0, 1);
        chk("post_rst_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter: serialises bytes onto `tx`, LSB first, one start bit and one stop bit.
- Small input FIFO with a valid/ready handshake, so producers (terminal logic, host echo path) can queue several bytes without waiting per byte.
- Sits in the clk100 domain, beside uart_rx, sharing the same baud divisor convention.

Parameters:
- BAUD_DIVISOR, 868, clk100 cycles per serial bit (115200 baud at 100 MHz); 10-bit value, legal range 2..1023.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries (default 4).

Ports:
- clk100  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  8  byte to send; sampled when tx_valid && tx_ready.
- tx_valid  in  1  producer has a byte on tx_data.
- tx_ready  out  1  FIFO can accept a byte this cycle (= FIFO not full).
- tx  out  1  serial line, registered; idle high.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_level  out  FIFO_AW+1  number of queued bytes (0..depth); excludes the byte being shifted.

Behaviour:
- Reset values (first edge with rst=1): tx=1, tx_ready=1, busy=0, fifo_level=0, FSM=IDLE, timer=0, bit counter=0.
- Reset mid-frame: tx=1 on the next edge; the frame is aborted and the FIFO is flushed; no partial byte resumes.
- Handshake:
  - A push occurs on an edge where tx_valid && tx_ready.
  - tx_ready = (fifo_level != depth), derived from registered state only, with no combinational path from tx_valid.
  - tx_valid while full has no effect; tx_data is held by the producer until accepted.
- FIFO:
  - Circular buffer; write and read pointers are FIFO_AW bits and wrap naturally.
  - fifo_level is a separate (FIFO_AW+1)-bit count.
  - Push and pop on the same edge: level unchanged, both pointers advance.
  - A pop never occurs when empty; a push never occurs when full.
- Bit timing:
  - Every bit (start, data, stop) lasts exactly BAUD_DIVISOR clk100 cycles.
  - The timer reloads with BAUD_DIVISOR-1 at each bit start and counts down to 0.
  - The bit ends on the edge where timer==0.
- FSM:
  - IDLE:
    - tx=1.
    - If fifo_level!=0: pop the head into the shift register, tx<=0, timer<=BAUD_DIVISOR-1, go to START.
  - START:
    - At timer==0: tx<=shift[0], shift right, bit counter<=0, reload timer, go to DATA.
  - DATA:
    - At timer==0 with bit counter<7: tx<=next LSB, counter+1, reload timer.
    - At timer==0 with counter==7: tx<=1, reload timer, go to STOP.
  - STOP:
    - At timer==0, if fifo_level!=0: pop, tx<=0, reload timer, go to START. Back-to-back frames have no idle gap.
    - Otherwise: go to IDLE with tx staying 1.
- Latency: a byte accepted at edge N into an empty FIFO with the FSM in IDLE gives tx low from edge N+1.
- Frame length: 10*BAUD_DIVISOR cycles.
- busy = (FSM!=IDLE) || (fifo_level!=0).
- busy falls on the edge where STOP ends with the FIFO empty.

Test Plan:
- BAUD_DIVISOR=4: reset, then push 0xA5 at edge N -> tx low at N+1 for 4 cycles, then data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high for 4 cycles; busy falls at N+41.
- BAUD_DIVISOR=4: push 0x00, 0xFF, 0x55 on consecutive cycles -> three contiguous 40-cycle frames with no idle gap; fifo_level peaks at 2.
- Hold tx_valid high with incrementing data 0x10.. while the FIFO fills (FIFO_AW=2) -> tx_ready low once level=4. The bytes accepted are exactly those on edges with tx_ready=1, and they appear on tx in order with none dropped or duplicated.
- Full FIFO during STOP end with tx_valid held -> pop frees a slot and tx_ready rises the next cycle; the pending byte is accepted and sent later in order.
- Assert rst during DATA bit 3 with 2 bytes queued -> tx=1, fifo_level=0, busy=0 after that edge. After deassert, push 0x3C -> clean frame for 0x3C only.
- Loopback: tx wired to uart_rx (both BAUD_DIVISOR=868), send 0x00..0xFF -> rx_complete pulses 256 times with matching rx_data.
